// File: rtl/bp_be_vcache_assoc.sv
// Fully associative victim cache holding blocks evicted from L1.
// A lookup hit hands the block back and invalidates it, keeping L1 and the victim cache exclusive.
module bp_be_vcache_assoc #(
    parameter int entries_p     = 8,
    parameter int block_width_p = 512,
    parameter int tag_width_p   = 26,
    localparam int age_w_lp     = $clog2(entries_p),
    localparam int occ_w_lp     = $clog2(entries_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     ins_v_i,
    input  logic [tag_width_p-1:0]   ins_tag_i,
    input  logic [block_width_p-1:0] ins_data_i,
    output logic                     ins_ready_o,
    input  logic                     lkup_v_i,
    input  logic [tag_width_p-1:0]   lkup_tag_i,
    output logic                     lkup_ready_o,
    input  logic                     flush_i,
    output logic                     resp_v_o,
    output logic                     resp_hit_o,
    output logic [block_width_p-1:0] resp_data_o,
    output logic [occ_w_lp-1:0]      occupancy_o
);

    logic [entries_p-1:0]                valid_r, valid_n;
    logic [entries_p-1:0][age_w_lp-1:0]  age_r, age_n;
    logic [tag_width_p-1:0]              tag_r  [entries_p];
    logic [block_width_p-1:0]            data_r [entries_p];
    logic [occ_w_lp-1:0]                 occ_r, occ_n;

    logic [entries_p-1:0]     lkup_match, ins_match;
    logic [entries_p-1:0]     free_oh, victim_oh, fill_oh, wr_en;
    logic                     free_found;
    logic                     lkup_fire, ins_fire, lkup_hit, ins_hit, full;
    logic [age_w_lp-1:0]      hit_age, ins_age;
    logic [block_width_p-1:0] hit_data;

    logic                     resp_v_r, resp_hit_r;
    logic [block_width_p-1:0] resp_data_r;

    assign lkup_ready_o = ~flush_i;
    assign ins_ready_o  = ~flush_i & ~lkup_v_i;
    assign lkup_fire    = lkup_v_i & lkup_ready_o;
    assign ins_fire     = ins_v_i & ins_ready_o;
    assign lkup_hit     = |lkup_match;
    assign ins_hit      = |ins_match;
    assign full         = (occ_r == occ_w_lp'(entries_p));
    assign fill_oh      = full ? victim_oh : free_oh;

    // Matches are one-hot, so OR-reducing the selected fields picks the hit entry.
    always_comb begin
        lkup_match = '0;
        ins_match  = '0;
        victim_oh  = '0;
        free_oh    = '0;
        free_found = 1'b0;
        hit_age    = '0;
        ins_age    = '0;
        hit_data   = '0;
        for (int i = 0; i < entries_p; i++) begin
            lkup_match[i] = valid_r[i] && (tag_r[i] == lkup_tag_i);
            ins_match[i]  = valid_r[i] && (tag_r[i] == ins_tag_i);
            victim_oh[i]  = valid_r[i] && (age_r[i] == age_w_lp'(entries_p - 1));
            if (!valid_r[i] && !free_found) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
            hit_age  = hit_age | ({age_w_lp{lkup_match[i]}} & age_r[i]);
            ins_age  = ins_age | ({age_w_lp{ins_match[i]}} & age_r[i]);
            hit_data = hit_data | ({block_width_p{lkup_match[i]}} & data_r[i]);
        end
    end

    always_comb begin
        valid_n = valid_r;
        age_n   = age_r;
        occ_n   = occ_r;
        wr_en   = '0;
        if (flush_i) begin
            valid_n = '0;
            age_n   = '0;
            occ_n   = '0;
        end else if (lkup_fire && lkup_hit) begin
            occ_n = occ_r - 1'b1;
            for (int i = 0; i < entries_p; i++) begin
                if (lkup_match[i]) begin
                    valid_n[i] = 1'b0;
                    age_n[i]   = '0;
                end else if (valid_r[i] && age_r[i] > hit_age) begin
                    age_n[i] = age_r[i] - 1'b1;
                end
            end
        end else if (ins_fire && ins_hit) begin
            wr_en = ins_match;
            for (int i = 0; i < entries_p; i++) begin
                if (ins_match[i])
                    age_n[i] = '0;
                else if (valid_r[i] && age_r[i] < ins_age)
                    age_n[i] = age_r[i] + 1'b1;
            end
        end else if (ins_fire) begin
            wr_en = fill_oh;
            if (!full)
                occ_n = occ_r + 1'b1;
            for (int i = 0; i < entries_p; i++) begin
                if (fill_oh[i]) begin
                    valid_n[i] = 1'b1;
                    age_n[i]   = '0;
                end else if (valid_r[i]) begin
                    age_n[i] = age_r[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_r     <= '0;
            age_r       <= '0;
            occ_r       <= '0;
            resp_v_r    <= 1'b0;
            resp_hit_r  <= 1'b0;
            resp_data_r <= '0;
        end else begin
            valid_r     <= valid_n;
            age_r       <= age_n;
            occ_r       <= occ_n;
            resp_v_r    <= lkup_fire;
            resp_hit_r  <= lkup_fire & lkup_hit;
            resp_data_r <= (lkup_fire && lkup_hit) ? hit_data : '0;
        end
    end

    // Tag/data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < entries_p; i++) begin
            if (wr_en[i]) begin
                tag_r[i]  <= ins_tag_i;
                data_r[i] <= ins_data_i;
            end
        end
    end

    assign resp_v_o    = resp_v_r;
    assign resp_hit_o  = resp_hit_r;
    assign resp_data_o = resp_data_r;
    assign occupancy_o = occ_r;

endmodule

// File: tb/tb_bp_be_vcache_assoc.sv
// Scoreboard bench for the victim cache: stimulus pushes expected
// lookup responses, a negedge monitor pops and compares them.
module tb_bp_be_vcache_assoc;

    localparam int E  = 4;
    localparam int BW = 32;
    localparam int TW = 8;
    localparam int OW = $clog2(E + 1);

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          ins_v_i = 1'b0;
    logic [TW-1:0] ins_tag_i = '0;
    logic [BW-1:0] ins_data_i = '0;
    logic          ins_ready_o;
    logic          lkup_v_i = 1'b0;
    logic [TW-1:0] lkup_tag_i = '0;
    logic          lkup_ready_o;
    logic          flush_i = 1'b0;
    logic          resp_v_o;
    logic          resp_hit_o;
    logic [BW-1:0] resp_data_o;
    logic [OW-1:0] occupancy_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic [BW:0] exp_q [$];
    logic [BW:0] exp_e;

    bp_be_vcache_assoc #(
        .entries_p    (E),
        .block_width_p(BW),
        .tag_width_p  (TW)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .ins_v_i     (ins_v_i),
        .ins_tag_i   (ins_tag_i),
        .ins_data_i  (ins_data_i),
        .ins_ready_o (ins_ready_o),
        .lkup_v_i    (lkup_v_i),
        .lkup_tag_i  (lkup_tag_i),
        .lkup_ready_o(lkup_ready_o),
        .flush_i     (flush_i),
        .resp_v_o    (resp_v_o),
        .resp_hit_o  (resp_hit_o),
        .resp_data_o (resp_data_o),
        .occupancy_o (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (resp_v_o) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL resp_unexpected: got resp_v 1 want 0");
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("resp_hit", 64'(resp_hit_o), 64'(exp_e[BW]));
                    chk("resp_data", 64'(resp_data_o), 64'(exp_e[BW-1:0]));
                end
            end else begin
                chk("idle_resp", 64'({resp_hit_o, resp_data_o}), 64'd0);
            end
        end
    end

    task automatic do_ins(input logic [TW-1:0] t, input logic [BW-1:0] d);
        ins_v_i    = 1'b1;
        ins_tag_i  = t;
        ins_data_i = d;
        @(posedge clk_i);
        #1 ins_v_i = 1'b0;
    endtask

    task automatic do_lkup(input logic [TW-1:0] t, input logic h,
                           input logic [BW-1:0] d);
        lkup_v_i   = 1'b1;
        lkup_tag_i = t;
        exp_q.push_back({h, d});
        @(posedge clk_i);
        #1 lkup_v_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst_resp_v", 64'(resp_v_o), 64'd0);
        chk("rst_occ", 64'(occupancy_o), 64'd0);
        #11 reset_i = 1'b0;
        @(posedge clk_i);
        #1;

        do_lkup(8'h05, 1'b0, 32'h0);
        chk("occ_empty", 64'(occupancy_o), 64'd0);

        do_ins(8'h0A, 32'd1);
        do_ins(8'h0B, 32'd2);
        do_ins(8'h0C, 32'd3);
        do_ins(8'h0D, 32'd4);
        chk("occ_full", 64'(occupancy_o), 64'd4);
        do_ins(8'h0E, 32'd5);
        chk("occ_evict", 64'(occupancy_o), 64'd4);
        do_lkup(8'h0A, 1'b0, 32'h0);
        do_lkup(8'h0B, 1'b1, 32'd2);
        chk("occ_after_hit", 64'(occupancy_o), 64'd3);
        do_lkup(8'h0B, 1'b0, 32'h0);

        // Cache holds E0 D1 C2; refill B then overwrite it in place.
        do_ins(8'h0B, 32'd7);
        do_ins(8'h0B, 32'd9);
        chk("occ_overwrite", 64'(occupancy_o), 64'd4);
        do_ins(8'h0F, 32'd6);
        chk("occ_full2", 64'(occupancy_o), 64'd4);
        do_lkup(8'h0C, 1'b0, 32'h0);
        do_lkup(8'h0B, 1'b1, 32'd9);
        chk("occ_3", 64'(occupancy_o), 64'd3);

        // F0 E1 D2: refresh D, add G, then H evicts E.
        do_ins(8'h0D, 32'h44);
        do_ins(8'h10, 32'd7);
        do_ins(8'h11, 32'd8);
        do_lkup(8'h0E, 1'b0, 32'h0);
        do_lkup(8'h0D, 1'b1, 32'h44);
        do_lkup(8'h0F, 1'b1, 32'd6);
        do_lkup(8'h10, 1'b1, 32'd7);
        do_lkup(8'h11, 1'b1, 32'd8);
        chk("occ_drained", 64'(occupancy_o), 64'd0);

        ins_v_i    = 1'b1;
        ins_tag_i  = 8'h21;
        ins_data_i = 32'h21;
        lkup_v_i   = 1'b1;
        lkup_tag_i = 8'h21;
        exp_q.push_back({1'b0, 32'h0});
        #1;
        chk("ins_ready_blocked", 64'(ins_ready_o), 64'd0);
        chk("lkup_ready", 64'(lkup_ready_o), 64'd1);
        @(posedge clk_i);
        #1 lkup_v_i = 1'b0;
        #1 chk("ins_ready_free", 64'(ins_ready_o), 64'd1);
        @(posedge clk_i);
        #1 ins_v_i = 1'b0;
        chk("occ_conflict", 64'(occupancy_o), 64'd1);
        do_lkup(8'h21, 1'b1, 32'h21);

        do_ins(8'h31, 32'h31);
        do_ins(8'h32, 32'h32);
        do_ins(8'h33, 32'h33);
        chk("occ_pre_flush", 64'(occupancy_o), 64'd3);
        flush_i    = 1'b1;
        lkup_v_i   = 1'b1;
        lkup_tag_i = 8'h31;
        #1;
        chk("flush_lkup_ready", 64'(lkup_ready_o), 64'd0);
        chk("flush_ins_ready", 64'(ins_ready_o), 64'd0);
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        lkup_v_i = 1'b0;
        chk("occ_flush", 64'(occupancy_o), 64'd0);
        do_lkup(8'h31, 1'b0, 32'h0);
        do_lkup(8'h32, 1'b0, 32'h0);
        do_lkup(8'h33, 1'b0, 32'h0);

        do_ins(8'h41, 32'h41);
        do_ins(8'h42, 32'h42);
        lkup_v_i   = 1'b1;
        lkup_tag_i = 8'h41;
        @(posedge clk_i);
        #1 lkup_v_i = 1'b0;
        chk("pre_rst_resp_v", 64'(resp_v_o), 64'd1);
        chk("pre_rst_occ", 64'(occupancy_o), 64'd1);
        reset_i = 1'b1;
        #1;
        chk("async_rst_resp_v", 64'(resp_v_o), 64'd0);
        chk("async_rst_hit", 64'(resp_hit_o), 64'd0);
        chk("async_rst_data", 64'(resp_data_o), 64'd0);
        chk("async_rst_occ", 64'(occupancy_o), 64'd0);
        ins_v_i    = 1'b1;
        ins_tag_i  = 8'h55;
        ins_data_i = 32'h55;
        @(posedge clk_i);
        #1 ins_v_i = 1'b0;
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("occ_after_rst", 64'(occupancy_o), 64'd0);
        do_lkup(8'h42, 1'b0, 32'h0);
        do_lkup(8'h55, 1'b0, 32'h0);

        repeat (3) @(posedge clk_i);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bp_be_vcache_assoc.md
BP_BE_VCACHE_ASSOC -- requirements
Module: bp_be_vcache_assoc

Interface
REQ-001 SHALL have parameter entries_p, default 8: number of victim entries, power of two, >= 2.
REQ-002 SHALL have parameter block_width_p, default 512: data block width in bits.
REQ-003 SHALL have parameter tag_width_p, default 26: block tag width in bits.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port ins_v_i, input, 1: insert request valid (evicted L1 block).
REQ-007 SHALL have port ins_tag_i, input, tag_width_p: insert tag.
REQ-008 SHALL have port ins_data_i, input, block_width_p: insert data.
REQ-009 SHALL have port ins_ready_o, output, 1: insert accepted when ins_v_i & ins_ready_o.
REQ-010 SHALL have port lkup_v_i, input, 1: lookup request valid.
REQ-011 SHALL have port lkup_tag_i, input, tag_width_p: lookup tag.
REQ-012 SHALL have port lkup_ready_o, output, 1: lookup accepted when lkup_v_i & lkup_ready_o.
REQ-013 SHALL have port flush_i, input, 1: invalidate all entries.
REQ-014 SHALL have port resp_v_o, output, 1: lookup response valid.
REQ-015 SHALL have port resp_hit_o, output, 1: lookup hit.
REQ-016 SHALL have port resp_data_o, output, block_width_p: hit data, zero on miss.
REQ-017 SHALL have port occupancy_o, output, $clog2(entries_p+1): count of valid entries.

Function
REQ-018 Each entry SHALL hold valid bit, tag, data and an age of $clog2(entries_p) bits; only valid entries participate in matching.
REQ-019 Ages of valid entries SHALL always be unique and span 0..occupancy-1; 0 = MRU, occupancy-1 = LRU.
REQ-020 lkup_ready_o SHALL equal ~flush_i; ins_ready_o SHALL equal ~flush_i & ~lkup_v_i (lookup has priority).
REQ-021 An accepted lookup SHALL produce resp_v_o=1 for exactly one cycle on the following cycle, with resp_hit_o and resp_data_o registered alongside; there is no response backpressure.
REQ-022 On lookup hit, the matching entry SHALL be invalidated at the same edge (exclusive with L1), occupancy decremented, and ages greater than the removed age decremented.
REQ-023 On lookup miss, state SHALL be unchanged and resp_data_o SHALL be 0.
REQ-024 Accepted insert whose tag matches a valid entry SHALL overwrite that entry's data, set its age to 0, increment ages less than its prior age; occupancy unchanged.
REQ-025 Otherwise, if not full, insert SHALL fill the lowest-index invalid entry with age 0, increment all valid ages, and increment occupancy.
REQ-026 Otherwise (full), insert SHALL replace the entry with age entries_p-1, set it to age 0, increment all other ages; occupancy stays entries_p.
REQ-027 flush_i SHALL clear all valid bits and ages and zero occupancy at the next edge; no lookup or insert is accepted that cycle; resp_v_o is 0 the following cycle.
REQ-028 At most one valid entry SHALL ever match a given tag.
REQ-029 Cycles with no accepted lookup SHALL drive resp_v_o=0, resp_hit_o=0, resp_data_o=0 on the next cycle.

Reset
REQ-030 reset_i assertion SHALL immediately, without clock, clear all valid bits, ages, resp_v_o, resp_hit_o, resp_data_o and occupancy_o to 0; tag/data storage need not be reset.
REQ-031 Requests presented while reset_i is high SHALL be ignored; normal operation resumes at the first rising edge after deassertion.

Verification (entries_p=4)
REQ-032 Reset then lookup tag 0x5 -> next cycle resp_v_o=1, resp_hit_o=0, resp_data_o=0, occupancy_o=0.
REQ-033 Insert tags 0xA,0xB,0xC,0xD data 1..4, then 0xE data 5 -> occupancy 4; lookup 0xA misses; lookup 0xB hits data 2, occupancy drops to 3; second lookup 0xB misses.
REQ-034 With 0xB present, insert 0xB data 9 -> occupancy unchanged; next insert into a full cache evicts LRU, not 0xB; lookup 0xB returns 9.
REQ-035 ins_v_i and lkup_v_i high same cycle -> ins_ready_o=0, lookup responds next cycle, insert accepted one cycle later when lkup_v_i drops.
REQ-036 Three inserts then flush_i for one cycle -> occupancy_o=0, all three tags miss afterwards.
REQ-037 reset_i asserted mid-cycle while resp_v_o=1 -> resp_v_o and occupancy_o go 0 before next clock edge.
